rtc_bus_controller: RTL and testbench

Drives the RTC chip's multiplexed address/data parallel bus (Intel-style A/D, CS, RD, WR strobes) on behalf of the PicoBlaze port register bank. On a write request it copies the nine date/time/timer registers into the RTC. On a read request it fetches the same nine registers and presents them to the port bank as the read-back set, with a done pulse. Sits between the PicoBlaze port register bank and the top-level RTC pins.

---
 rtl/rtc_bus_controller_if.sv | 13 +
 rtl/rtc_bus_controller.sv | 174 +++++++++++++++++
 tb/tb_rtc_bus_controller.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_controller_if.sv
// RTC multiplexed A/D bus pins; master = controller, slave = RTC side.
interface rtc_bus_controller_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_sel;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  modport master (output cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe, input ad_in);
  modport slave  (input cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe, output ad_in);
endinterface

// File: rtl/rtc_bus_controller.sv
// Copies nine date/time/timer registers to/from the RTC over its A/D bus; listo 9*2*(T_PULSE+T_GAP)+1 cycles after accept.
// No backpressure: requests are sampled only in IDLE. RTC_TRANSFER_CMD_EN adds 0xF0/0xF1 command accesses.
module rtc_bus_controller #(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_wr,
  input  logic       start_rd,
  input  logic [7:0] ano, mes, dia, horas, minutos, segundos, ht, mt, st,
  output logic [7:0] anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle,
  output logic       busy,
  output logic       listo,
  rtc_bus_controller_if.master bus
);
  localparam int TMAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] P_LD = TW'(T_PULSE - 1);
  localparam logic [TW-1:0] G_LD = TW'(T_GAP - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APULSE = 3'd1;
  localparam logic [2:0] S_AGAP   = 3'd2;
  localparam logic [2:0] S_DPULSE = 3'd3;
  localparam logic [2:0] S_DGAP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state;
  logic [3:0]    index;
  logic [TW-1:0] timer;
  logic          is_rd;
  logic          is_cmd;
  logic [7:0]    wdat   [9];
  logic [7:0]    shadow [9];
  logic [7:0]    le     [9];
  logic [7:0]    addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      index  <= '0;
      timer  <= '0;
      is_rd  <= 1'b0;
      is_cmd <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        wdat[i]   <= '0;
        shadow[i] <= '0;
        le[i]     <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start_wr || start_rd) begin
            is_rd   <= !start_wr;
            wdat[0] <= ano;     wdat[1] <= mes;      wdat[2] <= dia;
            wdat[3] <= horas;   wdat[4] <= minutos;  wdat[5] <= segundos;
            wdat[6] <= ht;      wdat[7] <= mt;       wdat[8] <= st;
            index   <= '0;
            timer   <= P_LD;
            state   <= S_APULSE;
`ifdef RTC_TRANSFER_CMD_EN
            is_cmd  <= !start_wr;
`else
            is_cmd  <= 1'b0;
`endif
          end
        end
        S_APULSE: begin
          if (timer == '0) begin
            state <= S_AGAP;
            timer <= G_LD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_AGAP: begin
          if (timer == '0) begin
            timer <= P_LD;
            if (is_cmd) begin
              // Command accesses have no data phase: read proceeds to index 0, write is finished.
              is_cmd <= 1'b0;
              state  <= is_rd ? S_APULSE : S_DONE;
            end else begin
              state <= S_DPULSE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DPULSE: begin
          if (timer == '0) begin
            state <= S_DGAP;
            timer <= G_LD;
            if (is_rd) shadow[index] <= bus.ad_in;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DGAP: begin
          if (timer == '0) begin
            timer <= P_LD;
            if (index == 4'd8) begin
              index <= '0;
`ifdef RTC_TRANSFER_CMD_EN
              if (!is_rd) begin
                is_cmd <= 1'b1;
                state  <= S_APULSE;
              end else begin
                state <= S_DONE;
                le    <= shadow;
              end
`else
              state <= S_DONE;
              if (is_rd) le <= shadow;
`endif
            end else begin
              index <= index + 1'b1;
              state <= S_APULSE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    addr = 8'h00;
    case (index)
      4'd0: addr = 8'h26;
      4'd1: addr = 8'h25;
      4'd2: addr = 8'h24;
      4'd3: addr = 8'h23;
      4'd4: addr = 8'h22;
      4'd5: addr = 8'h21;
      4'd6: addr = 8'h43;
      4'd7: addr = 8'h42;
      4'd8: addr = 8'h41;
      default: addr = 8'h00;
    endcase
    if (is_cmd) addr = is_rd ? 8'hF0 : 8'hF1;
  end

  always_comb begin
    bus.ad_out = 8'h00;
    if (state == S_APULSE || state == S_AGAP)
      bus.ad_out = addr;
    else if (state == S_DPULSE && !is_rd)
      bus.ad_out = wdat[index];
  end

  assign bus.cs_n   = !(state == S_APULSE || state == S_DPULSE);
  assign bus.wr_n   = !(state == S_APULSE || (state == S_DPULSE && !is_rd));
  assign bus.rd_n   = !(state == S_DPULSE && is_rd);
  assign bus.ad_sel = !(state == S_APULSE || state == S_AGAP);
  assign bus.ad_oe  = (state == S_APULSE) || (state == S_AGAP) || (state == S_DPULSE && !is_rd);

  assign busy  = (state != S_IDLE) && (state != S_DONE);
  assign listo = (state == S_DONE);

  assign anole      = le[0];
  assign mesle      = le[1];
  assign diale      = le[2];
  assign horasle    = le[3];
  assign minutosle  = le[4];
  assign segundosle = le[5];
  assign htle       = le[6];
  assign mtle       = le[7];
  assign stle       = le[8];
endmodule

// File: tb/tb_rtc_bus_controller.sv
// Directed bench for rtc_bus_controller with a bus monitor and an RTC model returning addr+0x10.
`timescale 1ns/1ps
module tb_rtc_bus_controller;
`ifdef RTC_TRANSFER_CMD_EN
  localparam int CMD = 1;
`else
  localparam int CMD = 0;
`endif
  localparam int LAT = 271 + 15 * CMD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_wr, start_rd, busy, listo;
  logic [7:0] ano, mes, dia, horas, minutos, segundos, ht, mt, st;
  logic [7:0] anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle;
  logic [7:0] rtc_addr = 8'h00;

  rtc_bus_controller_if bus();
  assign bus.ad_in = rtc_addr + 8'h10;

  rtc_bus_controller #(.T_PULSE(10), .T_GAP(5)) dut (
    .clk(clk), .reset(reset), .start_wr(start_wr), .start_rd(start_rd),
    .ano(ano), .mes(mes), .dia(dia), .horas(horas), .minutos(minutos),
    .segundos(segundos), .ht(ht), .mt(mt), .st(st),
    .anole(anole), .mesle(mesle), .diale(diale), .horasle(horasle),
    .minutosle(minutosle), .segundosle(segundosle), .htle(htle), .mtle(mtle), .stle(stle),
    .busy(busy), .listo(listo), .bus(bus)
  );

  wire [71:0] le_all = {anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle};

  int checks = 0, errors = 0;
  int viol = 0, listo_cnt = 0;
  logic [7:0] addr_tab [9] = '{8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};
  logic [7:0] wr_tab   [9] = '{8'h16, 8'h05, 8'h23, 8'h14, 8'h30, 8'h45, 8'h00, 8'h01, 8'h30};

  // One log entry per strobe pulse: kind, ad_sel, value on the last low cycle, width.
  int mon_rd[$], mon_sel[$], mon_val[$], mon_w[$];
  int cur_w = 0, cur_rd = 0, cur_sel = 0, cur_val = 0;

  always @(negedge clk) begin
    if (!bus.rd_n && !bus.wr_n) viol++;
    if (bus.cs_n !== (bus.rd_n & bus.wr_n)) viol++;
    if (!bus.rd_n && bus.ad_oe) viol++;
    if (listo === 1'b1) listo_cnt++;
    if (!bus.wr_n || !bus.rd_n) begin
      cur_w++;
      cur_rd  = !bus.rd_n;
      cur_sel = bus.ad_sel;
      cur_val = bus.rd_n ? bus.ad_out : bus.ad_in;
      if (!bus.wr_n && !bus.ad_sel) rtc_addr = bus.ad_out;
    end else if (cur_w != 0) begin
      mon_rd.push_back(cur_rd);
      mon_sel.push_back(cur_sel);
      mon_val.push_back(cur_val);
      mon_w.push_back(cur_w);
      cur_w = 0;
    end
  end

  task automatic clear_log();
    mon_rd.delete(); mon_sel.delete(); mon_val.delete(); mon_w.delete();
  endtask

  task automatic load_wdata();
    ano = wr_tab[0]; mes = wr_tab[1]; dia = wr_tab[2]; horas = wr_tab[3]; minutos = wr_tab[4];
    segundos = wr_tab[5]; ht = wr_tab[6]; mt = wr_tab[7]; st = wr_tab[8];
  endtask

  task automatic test_reset();
    reset = 1'b1; start_wr = 1'b0; start_rd = 1'b0; load_wdata();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_sel, bus.ad_oe, busy, listo} !== 7'b1111000 ||
        bus.ad_out !== 8'h00 || le_all !== 72'h0) begin
      errors++;
      $display("FAIL reset_state got cs/rd/wr/sel/oe/busy/listo=%b ad_out=%h le=%h required 1111000 00 0",
               {bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_sel, bus.ad_oe, busy, listo}, bus.ad_out, le_all);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int base;
    start_wr = 1'b1; @(negedge clk); start_wr = 1'b0;
    repeat (139) @(negedge clk);
    checks++;
    if (bus.wr_n !== 1'b0 || bus.ad_sel !== 1'b1 || bus.ad_out !== 8'h30) begin
      errors++;
      $display("FAIL midwrite_phase got wr_n=%b sel=%b ad_out=%h required 0 1 30", bus.wr_n, bus.ad_sel, bus.ad_out);
    end
    base = listo_cnt;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe, busy} !== 5'b11100 || le_all !== 72'h0) begin
      errors++;
      $display("FAIL midwrite_reset got cs/rd/wr/oe/busy=%b le=%h required 11100 0",
               {bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe, busy}, le_all);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (320) @(negedge clk);
    checks++;
    if (listo_cnt !== base || busy !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_no_listo got listo_cnt=%0d busy=%b required %0d 0", listo_cnt, busy, base);
    end
  endtask

  task automatic test_write();
    int n, nexp, bad;
    clear_log(); load_wdata();
    start_wr = 1'b1; @(negedge clk); start_wr = 1'b0; n = 1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b required 1", busy); end
    while (listo !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL write_latency got %0d required %0d", n, LAT); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL write_done_busy got %b required 0", busy); end
    nexp = 18 + CMD;
    checks++;
    if (mon_val.size() !== nexp) begin
      errors++; $display("FAIL write_log_len got %0d required %0d", mon_val.size(), nexp);
    end else begin
      for (int i = 0; i < nexp; i++) begin
        int e_sel, e_val;
        e_sel = (i < 18) ? (i % 2) : 0;
        e_val = (i >= 18) ? 8'hF1 : ((i % 2) ? wr_tab[i/2] : addr_tab[i/2]);
        checks++;
        if (mon_rd[i] !== 0 || mon_sel[i] !== e_sel || mon_val[i] !== e_val || mon_w[i] !== 10) begin
          errors++;
          $display("FAIL write_pulse%0d got rd=%0d sel=%0d val=%h w=%0d required 0 %0d %h 10",
                   i, mon_rd[i], mon_sel[i], mon_val[i], mon_w[i], e_sel, e_val);
        end
      end
    end
    bad = viol;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL write_bus_rules got %0d violations required 0", bad); end
    @(negedge clk);
  endtask

  task automatic test_read();
    int n, early, nexp, k;
    clear_log(); early = 0;
    start_rd = 1'b1; @(negedge clk); start_rd = 1'b0; n = 1;
    while (listo !== 1'b1 && n < 400) begin
      if (le_all !== 72'h0) early++;
      @(negedge clk); n++;
    end
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL read_latency got %0d required %0d", n, LAT); end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL read_le_early got %0d cycles changed required 0", early); end
    checks++;
    if (le_all !== 72'h36_35_34_33_32_31_53_52_51) begin
      errors++; $display("FAIL read_le got %h required 363534333231535251", le_all);
    end
    nexp = 18 + CMD;
    checks++;
    if (mon_val.size() !== nexp) begin
      errors++; $display("FAIL read_log_len got %0d required %0d", mon_val.size(), nexp);
    end else begin
      if (CMD != 0) begin
        checks++;
        if (mon_rd[0] !== 0 || mon_sel[0] !== 0 || mon_val[0] !== 8'hF0) begin
          errors++; $display("FAIL read_cmd got rd=%0d sel=%0d val=%h required 0 0 f0", mon_rd[0], mon_sel[0], mon_val[0]);
        end
      end
      for (int i = 0; i < 18; i++) begin
        int e_val;
        k = i + CMD;
        e_val = (i % 2) ? (addr_tab[i/2] + 8'h10) : addr_tab[i/2];
        checks++;
        if (mon_rd[k] !== (i % 2) || mon_sel[k] !== (i % 2) || mon_val[k] !== e_val || mon_w[k] !== 10) begin
          errors++;
          $display("FAIL read_pulse%0d got rd=%0d sel=%0d val=%h w=%0d required %0d %0d %h 10",
                   i, mon_rd[k], mon_sel[k], mon_val[k], mon_w[k], i % 2, i % 2, e_val);
        end
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL read_bus_rules got %0d violations required 0", viol); end
    @(negedge clk);
  endtask

  task automatic test_both();
    int n, base, rds;
    clear_log(); base = listo_cnt;
    start_wr = 1'b1; start_rd = 1'b1; @(negedge clk); start_wr = 1'b0; start_rd = 1'b0; n = 1;
    while (listo !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    rds = 0;
    foreach (mon_rd[i]) if (mon_rd[i] != 0) rds++;
    checks++;
    if (rds !== 0 || mon_val.size() !== 18 + CMD) begin
      errors++; $display("FAIL both_write_only got rd_pulses=%0d pulses=%0d required 0 %0d", rds, mon_val.size(), 18 + CMD);
    end
    checks++;
    if (listo_cnt - base !== 1) begin errors++; $display("FAIL both_listo got %0d required 1", listo_cnt - base); end
    checks++;
    if (le_all !== 72'h36_35_34_33_32_31_53_52_51) begin
      errors++; $display("FAIL both_le_hold got %h required 363534333231535251", le_all);
    end
  endtask

  task automatic test_snapshot();
    int n;
    clear_log(); load_wdata();
    start_wr = 1'b1; @(negedge clk); start_wr = 1'b0; n = 1;
    ano = 8'h99;
    while (listo !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (mon_val.size() < 2 || mon_val[0] !== 8'h26 || mon_val[1] !== 8'h16) begin
      errors++;
      $display("FAIL snapshot got pulses=%0d first=%h second=%h required 26 16", mon_val.size(),
               (mon_val.size() > 0) ? mon_val[0] : -1, (mon_val.size() > 1) ? mon_val[1] : -1);
    end
    ano = 8'h16;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, m, base;
    base = listo_cnt;
    start_rd = 1'b1; @(negedge clk); n = 1;
    while (listo !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL b2b_first_latency got %0d required %0d", n, LAT); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || listo !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got busy=%b listo=%b required 0 0", busy, listo);
    end
    @(negedge clk); m = 2;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got busy=%b required 1", busy); end
    while (listo !== 1'b1 && m < 600) begin @(negedge clk); m++; end
    start_rd = 1'b0;
    checks++;
    if (m !== LAT + 1) begin errors++; $display("FAIL b2b_interval got %0d required %0d", m, LAT + 1); end
    repeat (40) @(negedge clk);
    checks++;
    if (listo_cnt - base !== 2 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_listo_count got %0d busy=%b required 2 0", listo_cnt - base, busy);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_write();
    test_read();
    test_both();
    test_snapshot();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
